// File: rtl/mips_defs.sv
// Shared MIPS opcode/funct encodings, decode-stage defaults and the D/X record
// used by the decode stage and its register file.
package mips_defs;

  localparam logic [5:0] OP_RTYPE = 6'h00;
  localparam logic [5:0] OP_JAL   = 6'h03;
  localparam logic [5:0] OP_BEQ   = 6'h04;
  localparam logic [5:0] OP_BNE   = 6'h05;
  localparam logic [5:0] OP_ANDI  = 6'h0C;
  localparam logic [5:0] OP_ORI   = 6'h0D;
  localparam logic [5:0] OP_XORI  = 6'h0E;
  localparam logic [5:0] OP_LB    = 6'h20;
  localparam logic [5:0] OP_LH    = 6'h21;
  localparam logic [5:0] OP_LW    = 6'h23;
  localparam logic [5:0] OP_LBU   = 6'h24;
  localparam logic [5:0] OP_LHU   = 6'h25;
  localparam logic [5:0] OP_SB    = 6'h28;
  localparam logic [5:0] OP_SH    = 6'h29;
  localparam logic [5:0] OP_SW    = 6'h2B;
  localparam logic [5:0] FUNCT_JR = 6'h08;

  localparam logic [31:0] SP_INIT_DEFAULT  = 32'h8012_0000;
  localparam logic [31:0] NOP_INSN_DEFAULT = 32'h0000_0000;

  typedef struct packed {
    logic        valid;
    logic [31:0] pc;
    logic [31:0] insn;
    logic [31:0] rs_data;
    logic [31:0] rt_data;
    logic [31:0] imm;
    logic [31:0] jtarget;
    logic [4:0]  dest;
    logic        regwr;
    logic        is_load;
  } dx_t;

  function automatic logic is_load_op(input logic [5:0] op);
    return (op == OP_LB) || (op == OP_LH) || (op == OP_LW) ||
           (op == OP_LBU) || (op == OP_LHU);
  endfunction

  // Instructions whose rt field is a source operand rather than a destination.
  function automatic logic reads_rt_op(input logic [5:0] op);
    return (op == OP_RTYPE) || (op == OP_SB) || (op == OP_SH) ||
           (op == OP_SW) || (op == OP_BEQ) || (op == OP_BNE);
  endfunction

endpackage

// File: rtl/regfile.sv
// 32x32 register file: two async read ports, one sync write port,
// $0 hardwired to zero and write-to-read bypass on matching indices.
module regfile
  import mips_defs::*;
#(
  parameter logic [31:0] SP_INIT = SP_INIT_DEFAULT
) (
  input  logic             clock,
  input  logic             reset,
  input  logic [1:0][4:0]  rd_addr,
  output logic [1:0][31:0] rd_data,
  input  logic             wb_en,
  input  logic [4:0]       wb_addr,
  input  logic [31:0]      wb_data
);

  logic [31:0] regs_reg [32];
  logic        wr_hit;

  assign wr_hit = wb_en && (wb_addr != 5'd0);

  always_ff @(posedge clock) begin
    if (reset) begin
      for (int i = 0; i < 32; i++) begin
        regs_reg[i] <= (i == 29) ? SP_INIT : 32'd0;
      end
    end else if (wr_hit) begin
      regs_reg[wb_addr] <= wb_data;
    end
  end

  generate
    for (genvar gi = 0; gi < 2; gi++) begin : g_rd
      assign rd_data[gi] = (rd_addr[gi] == 5'd0)                  ? 32'd0   :
                           (wr_hit && (wb_addr == rd_addr[gi]))   ? wb_data :
                                                                    regs_reg[rd_addr[gi]];
    end
  endgenerate

endmodule

// File: rtl/decode_stage.sv
// MIPS decode stage: field extraction, register read, load-use hazard
// detection and the D/X pipeline register.
module decode_stage
  import mips_defs::*;
#(
  parameter logic [31:0] SP_INIT  = SP_INIT_DEFAULT,
  parameter logic [31:0] NOP_INSN = NOP_INSN_DEFAULT
) (
  input  logic        clock,
  input  logic        reset,
  input  logic [31:0] pc_FD,
  input  logic [31:0] insn_in,
  input  logic        insn_valid,
  input  logic        stall_in,
  input  logic        wb_en,
  input  logic [4:0]  wb_addr,
  input  logic [31:0] wb_data,
  output logic        stall_out,
  output logic        valid_DX,
  output logic [31:0] pc_DX,
  output logic [31:0] insn_DX,
  output logic [31:0] rs_data_DX,
  output logic [31:0] rt_data_DX,
  output logic [31:0] imm_DX,
  output logic [31:0] jtarget_DX,
  output logic [4:0]  dest_DX,
  output logic        regwr_DX,
  output logic        is_load_DX
);

  logic [5:0]       opcode, funct;
  logic [4:0]       rs, rt, rd;
  logic [3:0]       pc_plus4_hi;
  logic [1:0][4:0]  rd_addr;
  logic [1:0][31:0] rd_data;
  logic             regwr_c, is_load_c, hazard;
  logic [4:0]       dest_c;
  logic [31:0]      imm_c;
  dx_t              decoded, dx_reg, dx_next;

  assign opcode      = insn_in[31:26];
  assign rs          = insn_in[25:21];
  assign rt          = insn_in[20:16];
  assign rd          = insn_in[15:11];
  assign funct       = insn_in[5:0];
  assign pc_plus4_hi = 4'((pc_FD + 32'd4) >> 28);
  assign rd_addr     = {rt, rs};

  regfile #(.SP_INIT(SP_INIT)) u_regfile (
    .clock   (clock),
    .reset   (reset),
    .rd_addr (rd_addr),
    .rd_data (rd_data),
    .wb_en   (wb_en),
    .wb_addr (wb_addr),
    .wb_data (wb_data)
  );

  always_comb begin
    is_load_c = is_load_op(opcode);
    if (opcode == OP_RTYPE)       regwr_c = (funct != FUNCT_JR);
    else if (opcode == OP_JAL)    regwr_c = 1'b1;
    else if (opcode[5:3] == 3'b001) regwr_c = 1'b1;  // 0x08..0x0F immediate ALU ops
    else                          regwr_c = is_load_c;

    if (!regwr_c)                 dest_c = 5'd0;
    else if (opcode == OP_RTYPE)  dest_c = rd;
    else if (opcode == OP_JAL)    dest_c = 5'd31;
    else                          dest_c = rt;

    if ((opcode == OP_ANDI) || (opcode == OP_ORI) || (opcode == OP_XORI))
      imm_c = {16'h0000, insn_in[15:0]};
    else
      imm_c = {{16{insn_in[15]}}, insn_in[15:0]};
  end

  always_comb begin
    decoded         = '0;
    decoded.valid   = 1'b1;
    decoded.pc      = pc_FD;
    decoded.insn    = insn_in;
    decoded.rs_data = rd_data[0];
    decoded.rt_data = rd_data[1];
    decoded.imm     = imm_c;
    decoded.jtarget = {pc_plus4_hi, insn_in[25:0], 2'b00};
    decoded.dest    = dest_c;
    decoded.regwr   = regwr_c;
    decoded.is_load = is_load_c;
  end

  // A load in D/X cannot forward to the instruction right behind it.
  assign hazard = dx_reg.valid && dx_reg.is_load && dx_reg.regwr &&
                  (dx_reg.dest != 5'd0) && insn_valid &&
                  ((dx_reg.dest == rs) || ((dx_reg.dest == rt) && reads_rt_op(opcode)));

  assign stall_out = hazard || stall_in;

  always_comb begin
    dx_next = dx_reg;
    if (!stall_in) begin
      if (hazard || !insn_valid) begin
        dx_next      = '0;
        dx_next.insn = NOP_INSN;
      end else begin
        dx_next = decoded;
      end
    end
  end

  always_ff @(posedge clock) begin
    if (reset) dx_reg <= '0;
    else       dx_reg <= dx_next;
  end

  assign valid_DX   = dx_reg.valid;
  assign pc_DX      = dx_reg.pc;
  assign insn_DX    = dx_reg.insn;
  assign rs_data_DX = dx_reg.rs_data;
  assign rt_data_DX = dx_reg.rt_data;
  assign imm_DX     = dx_reg.imm;
  assign jtarget_DX = dx_reg.jtarget;
  assign dest_DX    = dx_reg.dest;
  assign regwr_DX   = dx_reg.regwr;
  assign is_load_DX = dx_reg.is_load;

endmodule

// File: tb/tb_decode_stage.sv
// Self-checking bench for decode_stage: directed scenarios plus a randomized
// run against a rule-level reference model of the regfile and D/X entry.
module tb_decode_stage;

  logic        clock = 1'b0;
  logic        reset;
  logic [31:0] pc_FD, insn_in, wb_data;
  logic        insn_valid, stall_in, wb_en;
  logic [4:0]  wb_addr;
  logic        stall_out, valid_DX, regwr_DX, is_load_DX;
  logic [31:0] pc_DX, insn_DX, rs_data_DX, rt_data_DX, imm_DX, jtarget_DX;
  logic [4:0]  dest_DX;

  decode_stage dut (
    .clock(clock), .reset(reset), .pc_FD(pc_FD), .insn_in(insn_in),
    .insn_valid(insn_valid), .stall_in(stall_in), .wb_en(wb_en),
    .wb_addr(wb_addr), .wb_data(wb_data), .stall_out(stall_out),
    .valid_DX(valid_DX), .pc_DX(pc_DX), .insn_DX(insn_DX),
    .rs_data_DX(rs_data_DX), .rt_data_DX(rt_data_DX), .imm_DX(imm_DX),
    .jtarget_DX(jtarget_DX), .dest_DX(dest_DX), .regwr_DX(regwr_DX),
    .is_load_DX(is_load_DX)
  );

  always #5 clock = ~clock;

  typedef struct packed {
    logic        valid;
    logic [31:0] pc, insn, rs_d, rt_d, imm, jt;
    logic [4:0]  dest;
    logic        regwr, is_load;
  } exp_t;

  exp_t        m_dx, dut_dx, snap;
  logic [31:0] m_regs [32];
  logic        obs_stall, exp_stall;
  int          n_tests = 0;
  int          n_fail  = 0;

  assign dut_dx = {valid_DX, pc_DX, insn_DX, rs_data_DX, rt_data_DX, imm_DX,
                   jtarget_DX, dest_DX, regwr_DX, is_load_DX};

  // Register read as seen by the instruction: $0 is zero, a same-cycle write wins.
  function automatic logic [31:0] rd_reg(input logic [4:0] idx);
    if (idx == 0) return 32'd0;
    if (wb_en && wb_addr == idx) return wb_data;
    return m_regs[idx];
  endfunction

  function automatic exp_t ref_decode(input logic [31:0] pc, input logic [31:0] insn);
    exp_t e;
    int op, fn;
    logic [4:0] rs, rt, rd;
    op = int'(insn >> 26);
    fn = int'(insn & 32'h3F);
    rs = insn[25:21]; rt = insn[20:16]; rd = insn[15:11];
    e = '0;
    e.valid = 1'b1;
    e.pc    = pc;
    e.insn  = insn;
    e.rs_d  = rd_reg(rs);
    e.rt_d  = rd_reg(rt);
    if (op == 12 || op == 13 || op == 14) e.imm = insn & 32'h0000FFFF;
    else e.imm = insn[15] ? (insn | 32'hFFFF0000) : (insn & 32'h0000FFFF);
    e.jt = ((pc + 32'd4) & 32'hF000_0000) | ((insn & 32'h03FF_FFFF) << 2);
    e.is_load = (op == 32 || op == 33 || op == 35 || op == 36 || op == 37);
    e.regwr = (op == 0 && fn != 8) || (op >= 8 && op <= 15) || e.is_load || op == 3;
    if (e.regwr) e.dest = (op == 0) ? rd : (op == 3) ? 5'd31 : rt;
    return e;
  endfunction

  function automatic logic ref_hazard(input logic [31:0] insn, input logic iv);
    int op;
    logic reads_rt;
    op = int'(insn >> 26);
    reads_rt = (op == 0 || op == 4 || op == 5 || op == 40 || op == 41 || op == 43);
    return m_dx.valid && m_dx.is_load && m_dx.regwr && m_dx.dest != 0 && iv &&
           (m_dx.dest == insn[25:21] || (reads_rt && m_dx.dest == insn[20:16]));
  endfunction

  task automatic model_reset();
    m_dx = '0;
    for (int i = 0; i < 32; i++) m_regs[i] = (i == 29) ? 32'h8012_0000 : 32'd0;
  endtask

  // One clock of stimulus; records observed/expected stall_out and advances the model.
  task automatic cycle(input logic [31:0] pc, input logic [31:0] insn, input logic iv,
                       input logic st, input logic we, input logic [4:0] wa,
                       input logic [31:0] wd);
    exp_t nxt;
    logic hz;
    reset = 1'b0; pc_FD = pc; insn_in = insn; insn_valid = iv; stall_in = st;
    wb_en = we; wb_addr = wa; wb_data = wd;
    #1;
    hz = ref_hazard(insn, iv);
    exp_stall = hz | st;
    obs_stall = stall_out;
    if (st) nxt = m_dx;
    else if (hz || !iv) nxt = '0;
    else nxt = ref_decode(pc, insn);
    $display("[TB] pc=%h insn=%h v=%0d stall_in=%0d wb=%0d/%0d/%h stall_out=%0d",
             pc, insn, iv, st, we, wa, wd, obs_stall);
    @(posedge clock); #1;
    m_dx = nxt;
    if (we && wa != 0) m_regs[wa] = wd;
  endtask

  task automatic test_reset();
    reset = 1'b1; stall_in = 1'b0; insn_valid = 1'b1; insn_in = $urandom;
    pc_FD = $urandom; wb_en = 1'b1; wb_addr = 5'd29; wb_data = $urandom;
    repeat (2) @(posedge clock);
    #1;
    model_reset();
    n_tests++;
    if (dut_dx !== exp_t'(0)) begin
      n_fail++; $display("FAIL reset_dx: got %h want 0", dut_dx);
    end
    n_tests++;
    if (stall_out !== 1'b0) begin
      n_fail++; $display("FAIL reset_stall: got %b want 0", stall_out);
    end
    cycle(32'h0040_0000, 32'h03A0_1821, 1, 0, 0, 0, 0);
    n_tests++;
    if (rs_data_DX !== 32'h8012_0000) begin
      n_fail++; $display("FAIL reset_sp: got %h want 80120000", rs_data_DX);
    end
    n_tests++;
    if (dest_DX !== 5'd3 || valid_DX !== 1'b1) begin
      n_fail++; $display("FAIL reset_addu_dest: got dest=%0d v=%b want 3/1", dest_DX, valid_DX);
    end
    n_tests++;
    if (dut_dx !== m_dx) begin
      n_fail++; $display("FAIL reset_addu_dx: got %h want %h", dut_dx, m_dx);
    end
  endtask

  task automatic test_bypass();
    cycle(32'h0040_0010, 32'h00A0_3021, 1, 0, 1, 5, 32'hDEAD_BEEF);
    n_tests++;
    if (rs_data_DX !== 32'hDEAD_BEEF) begin
      n_fail++; $display("FAIL bypass: got %h want deadbeef", rs_data_DX);
    end
    cycle(32'h0040_0014, 32'h0000_0000, 0, 0, 1, 0, 32'h1234_5678);
    cycle(32'h0040_0018, 32'h0000_3021, 1, 0, 0, 0, 0);
    n_tests++;
    if (rs_data_DX !== 32'd0 || rt_data_DX !== 32'd0) begin
      n_fail++; $display("FAIL zero_reg: got %h/%h want 0/0", rs_data_DX, rt_data_DX);
    end
    cycle(32'h0040_001C, 32'h00A0_3021, 1, 0, 0, 0, 0);
    n_tests++;
    if (rs_data_DX !== 32'hDEAD_BEEF) begin
      n_fail++; $display("FAIL reg_stored: got %h want deadbeef", rs_data_DX);
    end
  endtask

  task automatic test_imm();
    cycle(32'h0040_0020, 32'h3402_8000, 1, 0, 0, 0, 0);
    n_tests++;
    if (imm_DX !== 32'h0000_8000 || dest_DX !== 5'd2 || regwr_DX !== 1'b1) begin
      n_fail++; $display("FAIL ori_imm: got imm=%h dest=%0d w=%b want 00008000/2/1",
                         imm_DX, dest_DX, regwr_DX);
    end
    cycle(32'h0040_0024, 32'h2402_FFFF, 1, 0, 0, 0, 0);
    n_tests++;
    if (imm_DX !== 32'hFFFF_FFFF) begin
      n_fail++; $display("FAIL addiu_imm: got %h want ffffffff", imm_DX);
    end
    cycle(32'h0040_0028, 32'h3002_FFFF, 1, 0, 0, 0, 0);
    n_tests++;
    if (imm_DX !== 32'h0000_FFFF) begin
      n_fail++; $display("FAIL andi_imm: got %h want 0000ffff", imm_DX);
    end
  endtask

  task automatic test_load_use();
    cycle(32'h0040_0100, 32'h8FA4_0000, 1, 0, 0, 0, 0);
    n_tests++;
    if (is_load_DX !== 1'b1 || dest_DX !== 5'd4 || obs_stall !== 1'b0) begin
      n_fail++; $display("FAIL lw_decode: got load=%b dest=%0d stall=%b want 1/4/0",
                         is_load_DX, dest_DX, obs_stall);
    end
    cycle(32'h0040_0104, 32'h0084_2821, 1, 0, 0, 0, 0);
    n_tests++;
    if (obs_stall !== 1'b1) begin
      n_fail++; $display("FAIL lu_stall: got %b want 1", obs_stall);
    end
    n_tests++;
    if (valid_DX !== 1'b0 || regwr_DX !== 1'b0 || dest_DX !== 5'd0) begin
      n_fail++; $display("FAIL lu_bubble: got v=%b w=%b d=%0d want 0/0/0",
                         valid_DX, regwr_DX, dest_DX);
    end
    cycle(32'h0040_0104, 32'h0084_2821, 1, 0, 0, 0, 0);
    n_tests++;
    if (obs_stall !== 1'b0) begin
      n_fail++; $display("FAIL lu_one_cycle: got stall=%b want 0", obs_stall);
    end
    n_tests++;
    if (valid_DX !== 1'b1 || pc_DX !== 32'h0040_0104 || dest_DX !== 5'd5) begin
      n_fail++; $display("FAIL lu_resume: got v=%b pc=%h d=%0d want 1/00400104/5",
                         valid_DX, pc_DX, dest_DX);
    end
  endtask

  task automatic test_store();
    cycle(32'h0040_0200, 32'h8FA4_0000, 1, 0, 0, 0, 0);
    cycle(32'h0040_0204, 32'hAFA4_0004, 1, 0, 0, 0, 0);
    n_tests++;
    if (obs_stall !== 1'b1) begin
      n_fail++; $display("FAIL sw_rt_stall: got %b want 1", obs_stall);
    end
    cycle(32'h0040_0204, 32'hAFA4_0004, 1, 0, 0, 0, 0);
    n_tests++;
    if (valid_DX !== 1'b1 || regwr_DX !== 1'b0 || dest_DX !== 5'd0) begin
      n_fail++; $display("FAIL sw_decode: got v=%b w=%b d=%0d want 1/0/0",
                         valid_DX, regwr_DX, dest_DX);
    end
    cycle(32'h0040_0208, 32'h8FA4_0000, 1, 0, 0, 0, 0);
    cycle(32'h0040_020C, 32'h24E6_0001, 1, 0, 0, 0, 0);
    n_tests++;
    if (obs_stall !== 1'b0 || valid_DX !== 1'b1) begin
      n_fail++; $display("FAIL addiu_no_stall: got stall=%b v=%b want 0/1", obs_stall, valid_DX);
    end
  endtask

  task automatic test_stall_hold();
    cycle(32'h0040_0300, 32'h00A0_3021, 1, 0, 0, 0, 0);
    snap = dut_dx;
    for (int k = 0; k < 3; k++) begin
      cycle(32'h0040_0304 + 32'(4 * k), $urandom, 1, 1, 0, 0, 0);
      n_tests++;
      if (obs_stall !== 1'b1 || dut_dx !== snap) begin
        n_fail++; $display("FAIL stall_hold[%0d]: got stall=%b dx=%h want 1/%h",
                           k, obs_stall, dut_dx, snap);
      end
    end
    reset = 1'b1; stall_in = 1'b1;
    @(posedge clock); #1;
    model_reset();
    n_tests++;
    if (dut_dx !== exp_t'(0)) begin
      n_fail++; $display("FAIL reset_mid_stall: got %h want 0", dut_dx);
    end
    reset = 1'b0; stall_in = 1'b0; #1;
    n_tests++;
    if (stall_out !== 1'b0) begin
      n_fail++; $display("FAIL stall_after_reset: got %b want 0", stall_out);
    end
  endtask

  task automatic test_random();
    int ops[24] = '{0, 0, 0, 0, 2, 3, 4, 5, 8, 9, 10, 12, 13, 14, 15,
                    32, 33, 35, 35, 36, 37, 40, 41, 43};
    int fns[8]  = '{8'h21, 8'h23, 8'h08, 8'h24, 8'h25, 8'h2A, 8'h00, 8'h26};
    logic [31:0] insn, pc;
    logic [4:0]  rs, rt, rd;
    pc = 32'h0040_1000;
    for (int n = 0; n < 400; n++) begin
      rs = 5'($urandom_range(0, 7)); rt = 5'($urandom_range(0, 7));
      rd = 5'($urandom_range(0, 7));
      if ($urandom_range(0, 9) == 0) rs = 5'd29;
      insn = {6'(ops[$urandom_range(0, 23)]), rs, rt, rd, 5'($urandom), 6'h00};
      if (insn[31:26] == 6'd0) insn[5:0] = 6'(fns[$urandom_range(0, 7)]);
      else insn[15:0] = 16'($urandom);
      cycle(pc, insn, $urandom_range(0, 9) != 0, $urandom_range(0, 6) == 0,
            $urandom_range(0, 1) == 1, 5'($urandom_range(0, 8)), $urandom);
      n_tests++;
      if (obs_stall !== exp_stall) begin
        n_fail++; $display("FAIL rnd_stall[%0d]: got %b want %b", n, obs_stall, exp_stall);
      end
      n_tests++;
      if (dut_dx !== m_dx) begin
        n_fail++; $display("FAIL rnd_dx[%0d]: got %h want %h", n, dut_dx, m_dx);
      end
      if (!obs_stall) pc = pc + 32'd4;
    end
  endtask

  initial begin
    test_reset();
    test_bypass();
    test_imm();
    test_load_use();
    test_store();
    test_stall_hold();
    test_random();
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
